game_time_keeper: RTL and testbench
===================================

// Module: game_time_keeper
// PURPOSE
//  Receiving end of the speed-scaled time base. Consumes the toggling 'newtime'
//  square wave from the speed controller; each rising edge is one game second.
//  Keeps the game clock (sec/min/hour/day) and emits one-cycle roll-over pulses.
//  Pulses drive pet-state decay, the display and event schedulers.
// PARAMETERS
//  SEC_MAX   59  last seconds value before wrap
//  MIN_MAX   59  last minutes value before wrap
//  HOUR_MAX  23  last hours value before wrap
//  DAY_W     8   day counter width; wraps 2^DAY_W-1 -> 0
// PORTS
//  clk        in   1      system clock, single clock domain
//  rst        in   1      reset, asynchronous, active-high
//  newtime    in   1      toggle time base, synchronous to clk; rising edge = 1 game s
//  pause      in   1      1 = ignore time-base edges; counters hold
//  set_en     in   1      1-cycle load strobe for hour/min
//  set_hour   in   5      value loaded into hour on set_en
//  set_min    in   6      value loaded into min on set_en
//  sec        out  6      game seconds, 0..SEC_MAX
//  min        out  6      game minutes, 0..MIN_MAX
//  hour       out  5      game hours, 0..HOUR_MAX
//  day        out  DAY_W  elapsed game days
//  sec_tick   out  1      1-cycle pulse per accepted second
//  min_tick   out  1      1-cycle pulse when sec wraps
//  hour_tick  out  1      1-cycle pulse when min wraps
//  day_tick   out  1      1-cycle pulse when hour wraps
// BEHAVIOUR
//  - Reset: sec=min=hour=day=0, all *_tick=0, edge register nt_q=1 (no spurious
//    edge if newtime is already high on reset release). Reset mid-count aborts all.
//  - Edge: rise = newtime & ~nt_q; nt_q <= newtime every cycle, incl. while paused.
//    Falling edges ignored. Unpause never replays missed edges.
//  - Accept = rise & ~pause & ~set_en. On the clk edge sampling the rise, counters
//    update; sec_tick (registered) is high the following cycle, same cycle new sec
//    is visible. min/hour/day_tick coincide with sec_tick on cascade.
//  - Cascade: sec==SEC_MAX -> sec=0, min+1, min_tick; min==MIN_MAX (and carry)
//    -> min=0, hour+1, hour_tick; hour==HOUR_MAX (and carry) -> hour=0, day+1,
//    day_tick; day wraps all-ones -> 0 silently (day_tick still fires).
//  - set_en: hour<=set_hour, min<=set_min, sec<=0, no tick pulses. Out-of-range
//    values clamp: hour>HOUR_MAX -> HOUR_MAX, min>MIN_MAX -> MIN_MAX. Day unchanged.
//  - set_en coincident with rise: load wins, the second is dropped.
//  - pause with set_en: load still applies.
//  - Max accepted rate: one second per 2 clk cycles (newtime toggling every cycle);
//    no tick is lost at that rate.
// STRUCTURE
//  - Package game_time_pkg: SEC_MAX/MIN_MAX/HOUR_MAX defaults, field widths
//    (SEC_W=6, MIN_W=6, HOUR_W=5), shared by display and scheduler blocks.
//  - Sub-module wrap_counter #(W, MAX): en, load, load_val -> q, wrap pulse;
//    instantiated four times (sec, min, hour, day) chained via wrap.
//  - Top level holds edge register, accept logic, clamp and tick output regs.
// TESTING
//  - Reset with newtime=1, hold 10 cycles -> no sec_tick, sec=0.
//  - 3 rising edges, pause=0 -> sec=3, exactly 3 sec_tick pulses, each 1 cycle.
//  - set 00:59:?? via set_en (hour=0,min=59), then 60 edges -> min=0, hour=1,
//    min_tick and hour_tick pulse together with 60th sec_tick.
//  - set hour=23,min=59, 60 edges -> hour=0, day=1, day_tick once.
//  - pause=1 over 5 edges, release -> sec unchanged, no tick after release.
//  - set_en same cycle as rise with set_hour=31,set_min=63 -> hour=23, min=59,
//    sec=0, no sec_tick; newtime toggling every cycle -> one tick per 2 cycles.

Source files
------------

// File: rtl/game_time_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : game_time_pkg                                            |
// | Description : Game-clock field widths and default wrap limits, shared  |
// |               by the time keeper, display and event scheduler blocks.  |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package game_time_pkg;

    // Field widths of the game clock
    localparam int unsigned SEC_W        = 6;
    localparam int unsigned MIN_W        = 6;
    localparam int unsigned HOUR_W       = 5;

    // Default last value of each field before it wraps to zero
    localparam int unsigned SEC_MAX_DEF  = 59;
    localparam int unsigned MIN_MAX_DEF  = 59;
    localparam int unsigned HOUR_MAX_DEF = 23;
    localparam int unsigned DAY_W_DEF    = 8;

endpackage : game_time_pkg
`default_nettype wire

// File: rtl/wrap_counter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : wrap_counter                                             |
// | Description : Loadable up-counter that wraps from MAX to zero. 'wrap'  |
// |               is the combinational carry out, high while en is set and |
// |               the counter holds MAX; it feeds the next counter's en.   |
// | Ports       : clk, rst (async, active-high), en (count), load (sync    |
// |               load, has priority over en), load_val, q, wrap.          |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module wrap_counter #(
    parameter int unsigned W   = 8,
    parameter int unsigned MAX = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q,
    output logic         wrap
);

    localparam logic [W-1:0] C_MAX = W'(MAX);
    localparam logic [W-1:0] C_ONE = W'(1);

    logic w_at_max;

    assign w_at_max = (q == C_MAX);
    assign wrap     = en & w_at_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= w_at_max ? '0 : (q + C_ONE);
        end
    end

endmodule : wrap_counter
`default_nettype wire

// File: rtl/game_time_keeper.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : game_time_keeper                                         |
// | Description : Game clock driven by the speed-scaled 'newtime' toggle.  |
// |               Each rising edge of newtime advances one game second;    |
// |               sec/min/hour/day cascade and emit one-cycle roll-over    |
// |               pulses aligned with the updated counter values.          |
// | Ports       : clk, rst (async, active-high), newtime, pause, set_en,   |
// |               set_hour, set_min -> sec, min, hour, day, sec_tick,      |
// |               min_tick, hour_tick, day_tick.                           |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module game_time_keeper
    import game_time_pkg::*;
#(
    parameter int unsigned SEC_MAX  = SEC_MAX_DEF,
    parameter int unsigned MIN_MAX  = MIN_MAX_DEF,
    parameter int unsigned HOUR_MAX = HOUR_MAX_DEF,
    parameter int unsigned DAY_W    = DAY_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              newtime,
    input  logic              pause,
    input  logic              set_en,
    input  logic [HOUR_W-1:0] set_hour,
    input  logic [MIN_W-1:0]  set_min,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic [DAY_W-1:0]  day,
    output logic              sec_tick,
    output logic              min_tick,
    output logic              hour_tick,
    output logic              day_tick
);

    localparam logic [HOUR_W-1:0] C_HOUR_MAX = HOUR_W'(HOUR_MAX);
    localparam logic [MIN_W-1:0]  C_MIN_MAX  = MIN_W'(MIN_MAX);
    localparam int unsigned       C_DAY_MAX  = (2 ** DAY_W) - 1;

    logic              r_nt_q;
    logic              w_rise;
    logic              w_accept;
    logic [HOUR_W-1:0] w_load_hour;
    logic [MIN_W-1:0]  w_load_min;
    logic              w_sec_wrap;
    logic              w_min_wrap;
    logic              w_hour_wrap;
    logic              w_day_wrap;
    logic              r_sec_tick;
    logic              r_min_tick;
    logic              r_hour_tick;
    logic              r_day_tick;

    // Edge register resets high so a newtime already high at reset release
    // is not mistaken for a rising edge. It tracks newtime even while paused,
    // so edges missed during pause are never replayed afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nt_q <= 1'b1;
        end else begin
            r_nt_q <= newtime;
        end
    end

    assign w_rise   = newtime & ~r_nt_q;
    // A load in the same cycle as a rise wins; that second is dropped.
    assign w_accept = w_rise & ~pause & ~set_en;

    assign w_load_hour = (set_hour > C_HOUR_MAX) ? C_HOUR_MAX : set_hour;
    assign w_load_min  = (set_min  > C_MIN_MAX)  ? C_MIN_MAX  : set_min;

    wrap_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
        .clk      (clk),
        .rst      (rst),
        .en       (w_accept),
        .load     (set_en),
        .load_val ('0),
        .q        (sec),
        .wrap     (w_sec_wrap)
    );

    wrap_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
        .clk      (clk),
        .rst      (rst),
        .en       (w_sec_wrap),
        .load     (set_en),
        .load_val (w_load_min),
        .q        (min),
        .wrap     (w_min_wrap)
    );

    wrap_counter #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
        .clk      (clk),
        .rst      (rst),
        .en       (w_min_wrap),
        .load     (set_en),
        .load_val (w_load_hour),
        .q        (hour),
        .wrap     (w_hour_wrap)
    );

    // Day count is never loaded; its wrap from all-ones is silent.
    wrap_counter #(.W(DAY_W), .MAX(C_DAY_MAX)) u_day (
        .clk      (clk),
        .rst      (rst),
        .en       (w_hour_wrap),
        .load     (1'b0),
        .load_val ('0),
        .q        (day),
        .wrap     (w_day_wrap)
    );

    // Ticks are registered from the same terms that advance the counters,
    // so each pulse is visible in the cycle the new count appears.
    // w_day_wrap can only be high together with w_hour_wrap, so OR-ing it
    // in leaves day_tick equal to the hour carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sec_tick  <= 1'b0;
            r_min_tick  <= 1'b0;
            r_hour_tick <= 1'b0;
            r_day_tick  <= 1'b0;
        end else begin
            r_sec_tick  <= w_accept;
            r_min_tick  <= w_sec_wrap;
            r_hour_tick <= w_min_wrap;
            r_day_tick  <= w_hour_wrap | w_day_wrap;
        end
    end

    assign sec_tick  = r_sec_tick;
    assign min_tick  = r_min_tick;
    assign hour_tick = r_hour_tick;
    assign day_tick  = r_day_tick;

endmodule : game_time_keeper
`default_nettype wire

// File: tb/tb_game_time_keeper.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_game_time_keeper                                      |
// | Description : Self-checking bench for game_time_keeper. Reference      |
// |               model keeps time of day as a plain seconds count.        |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_game_time_keeper;

    logic       clk;
    logic       rst;
    logic       newtime;
    logic       pause;
    logic       set_en;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [7:0] day;
    logic       sec_tick;
    logic       min_tick;
    logic       hour_tick;
    logic       day_tick;

    game_time_keeper dut (
        .clk       (clk),
        .rst       (rst),
        .newtime   (newtime),
        .pause     (pause),
        .set_en    (set_en),
        .set_hour  (set_hour),
        .set_min   (set_min),
        .sec       (sec),
        .min       (min),
        .hour      (hour),
        .day       (day),
        .sec_tick  (sec_tick),
        .min_tick  (min_tick),
        .hour_tick (hour_tick),
        .day_tick  (day_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: seconds since midnight plus day count
    int m_t;
    int m_day;
    bit m_prev;
    bit e_st, e_mt, e_ht, e_dt;

    int stick_cnt;
    int dtick_cnt;

    typedef struct {
        bit       nt;
        bit       p;
        bit       se;
        bit [4:0] sh;
        bit [5:0] sm;
        int       e_sec;
        int       e_min;
        int       e_hour;
        bit       e_tick;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit nt, input bit p, input bit se,
                              input int sh, input int sm);
        bit rise;
        rise   = nt && !m_prev;
        m_prev = nt;
        e_st = 0; e_mt = 0; e_ht = 0; e_dt = 0;
        if (se) begin
            m_t = ((sh > 23) ? 23 : sh) * 3600 + ((sm > 59) ? 59 : sm) * 60;
        end else if (rise && !p) begin
            m_t  = m_t + 1;
            e_st = 1;
            if (m_t % 60 == 0)   e_mt = 1;
            if (m_t % 3600 == 0) e_ht = 1;
            if (m_t == 86400) begin
                m_t   = 0;
                e_dt  = 1;
                m_day = (m_day + 1) % 256;
            end
        end
    endtask

    // One clock cycle: drive inputs, advance model at the edge, check after it.
    task automatic cycle(input bit nt, input bit p, input bit se,
                         input int sh, input int sm);
        newtime  = nt;
        pause    = p;
        set_en   = se;
        set_hour = 5'(sh);
        set_min  = 6'(sm);
        @(posedge clk);
        model_step(nt, p, se, sh, sm);
        #1;
        chk("sec",       int'(sec),       m_t % 60);
        chk("min",       int'(min),       (m_t / 60) % 60);
        chk("hour",      int'(hour),      m_t / 3600);
        chk("day",       int'(day),       m_day);
        chk("sec_tick",  int'(sec_tick),  int'(e_st));
        chk("min_tick",  int'(min_tick),  int'(e_mt));
        chk("hour_tick", int'(hour_tick), int'(e_ht));
        chk("day_tick",  int'(day_tick),  int'(e_dt));
        if (sec_tick) stick_cnt++;
        if (day_tick) dtick_cnt++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; newtime = 1'b1; pause = 1'b0; set_en = 1'b0;
        set_hour = '0; set_min = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_t = 0; m_day = 0; m_prev = 1'b1;
        e_st = 0; e_mt = 0; e_ht = 0; e_dt = 0;
        chk("rst_sec",  int'(sec),  0);
        chk("rst_min",  int'(min),  0);
        chk("rst_hour", int'(hour), 0);
        chk("rst_day",  int'(day),  0);
        chk("rst_ticks", int'({sec_tick, min_tick, hour_tick, day_tick}), 0);
    endtask

    initial begin
        int s_hold;
        rst = 1'b1; newtime = 1'b1; pause = 1'b0; set_en = 1'b0;
        set_hour = '0; set_min = '0;

        // Reset released with newtime already high: no spurious second
        do_reset();
        stick_cnt = 0;
        repeat (10) cycle(1, 0, 0, 0, 0);
        chk("idle_high_sec", int'(sec), 0);
        chk("idle_high_ticks", stick_cnt, 0);

        // Three rising edges
        stick_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 0);
            cycle(1, 0, 0, 0, 0);
        end
        cycle(0, 0, 0, 0, 0);
        chk("three_edges_sec", int'(sec), 3);
        chk("three_edges_ticks", stick_cnt, 3);

        // 00:59 + 60 seconds at maximum rate -> 01:00:00
        cycle(0, 0, 1, 0, 59);
        stick_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            cycle(1, 0, 0, 0, 0);
            if (i == 59) begin
                chk("hr_roll_sec_tick",  int'(sec_tick),  1);
                chk("hr_roll_min_tick",  int'(min_tick),  1);
                chk("hr_roll_hour_tick", int'(hour_tick), 1);
                chk("hr_roll_min",  int'(min),  0);
                chk("hr_roll_hour", int'(hour), 1);
            end
            cycle(0, 0, 0, 0, 0);
        end
        chk("max_rate_ticks", stick_cnt, 60);

        // 23:59 + 60 seconds -> day rolls
        cycle(0, 0, 1, 23, 59);
        dtick_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            cycle(1, 0, 0, 0, 0);
            cycle(0, 0, 0, 0, 0);
        end
        chk("day_roll_day", int'(day), 1);
        chk("day_roll_hour", int'(hour), 0);
        chk("day_roll_ticks", dtick_cnt, 1);

        // Pause over 5 edges, then release with newtime still high
        s_hold    = int'(sec);
        stick_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 0, 0, 0);
            cycle(1, 1, 0, 0, 0);
        end
        repeat (3) cycle(1, 0, 0, 0, 0);
        chk("pause_sec", int'(sec), s_hold);
        chk("pause_ticks", stick_cnt, 0);

        // Table-driven vectors from a fresh reset
        vecs[0]  = '{0, 0, 0,  0,  0, 0,  0,  0, 0};
        vecs[1]  = '{1, 0, 0,  0,  0, 1,  0,  0, 1};
        vecs[2]  = '{1, 0, 0,  0,  0, 1,  0,  0, 0};
        vecs[3]  = '{0, 0, 0,  0,  0, 1,  0,  0, 0};
        vecs[4]  = '{1, 1, 0,  0,  0, 1,  0,  0, 0};
        vecs[5]  = '{0, 0, 0,  0,  0, 1,  0,  0, 0};
        vecs[6]  = '{1, 0, 0,  0,  0, 2,  0,  0, 1};
        vecs[7]  = '{0, 0, 1,  5, 10, 0, 10,  5, 0};
        vecs[8]  = '{1, 0, 1, 31, 63, 0, 59, 23, 0};
        vecs[9]  = '{0, 0, 0,  0,  0, 0, 59, 23, 0};
        vecs[10] = '{1, 0, 0,  0,  0, 1, 59, 23, 1};
        vecs[11] = '{0, 0, 0,  0,  0, 1, 59, 23, 0};
        vecs[12] = '{1, 1, 1,  2,  3, 0,  3,  2, 0};
        vecs[13] = '{0, 0, 0,  0,  0, 0,  3,  2, 0};
        vecs[14] = '{1, 0, 0,  0,  0, 1,  3,  2, 1};
        vecs[15] = '{0, 0, 1, 24, 60, 0, 59, 23, 0};
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].nt, vecs[i].p, vecs[i].se,
                  int'(vecs[i].sh), int'(vecs[i].sm));
            chk($sformatf("vec%0d_sec", i),  int'(sec),  vecs[i].e_sec);
            chk($sformatf("vec%0d_min", i),  int'(min),  vecs[i].e_min);
            chk($sformatf("vec%0d_hour", i), int'(hour), vecs[i].e_hour);
            chk($sformatf("vec%0d_tick", i), int'(sec_tick), int'(vecs[i].e_tick));
        end

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bit rnt, rp, rse;
            int rsh, rsm;
            rnt = 1'($urandom_range(0, 1));
            rp  = ($urandom_range(0, 3) == 0);
            rse = ($urandom_range(0, 59) == 0);
            rsh = int'($urandom_range(0, 31));
            rsm = int'($urandom_range(0, 63));
            if (rse && $urandom_range(0, 1) == 1) begin
                rsh = 23;
                rsm = 59;
            end
            cycle(rnt, rp, rse, rsh, rsm);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_game_time_keeper
`default_nettype wire
